// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample types, limits and meter helpers for the monitor path
package audio_pkg;

  localparam int AUDIO_DATA_W  = 24;
  localparam int AUDIO_ATTEN_W = 4;
  localparam int ATTEN_MAX     = (1 << AUDIO_ATTEN_W) - 1;

  typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

  // Magnitude of a sign-extended sample of the given width. The most negative
  // code has no positive twin, so it is pulled down to the largest positive value.
  function automatic logic [63:0] abs_sat(input logic signed [63:0] x, input int width);
    logic [63:0] mag;
    mag = x[63] ? -x : x;
    if (mag == (64'd1 << (width - 1))) begin
      mag = mag - 64'd1;
    end
    return mag;
  endfunction

  // Peak level at which LED idx of the bar lights.
  function automatic logic [63:0] led_threshold(input int data_w, input int leds, input int idx);
    return 64'd1 << (data_w - 1 - leds + idx);
  endfunction

endpackage

// File: rtl/audio_monitor_pipeline_if.sv
// rtl/audio_monitor_pipeline_if.sv - sample stream bundle between deserializer, monitor and serializer
//   i_data/i_data_valid : packed input samples (ch0 at LSBs) with 1-cycle strobe
//   o_data/o_data_valid : packed processed samples with 1-cycle strobe
//   master: stream source/sink side, slave: the monitor pipeline
interface audio_monitor_pipeline_if #(
  parameter int DATA_W = audio_pkg::AUDIO_DATA_W,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*DATA_W-1:0] i_data;
  logic                     i_data_valid;
  logic [NUM_CH*DATA_W-1:0] o_data;
  logic                     o_data_valid;

  modport master (output i_data, output i_data_valid, input o_data, input o_data_valid);
  modport slave  (input i_data, input i_data_valid, output o_data, output o_data_valid);
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-FF synchroniser, stability counter and rising-edge pulse for one button
//   i_clock, i_reset : clock, async active-high reset
//   i_btn            : raw asynchronous button level
//   o_rise           : 1-cycle pulse when the debounced level goes high
module button_debouncer #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any bounce back resets it.
  always_comb begin
    sync_d   = {sync_q[0], i_btn};
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_d = sync_q[1];
        rise_d   = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_rise = rise_q;
endmodule

// File: rtl/audio_monitor_pipeline.sv
// rtl/audio_monitor_pipeline.sv - per-channel attenuation/mute pipeline with debounced buttons and peak-hold LED meter
//   i_clock, i_reset            : clock, async active-high reset
//   bus (slave)                 : i_data/i_data_valid in, o_data/o_data_valid out, 2-cycle latency
//   i_btn_up/down/sel/mute      : raw buttons acting on the selected channel
//   o_led                       : peak meter thermometer
//   o_sel_ch, o_mute            : selected channel, per-channel mute state
//   AUDIO_MON_SOFT_MUTE_EN      : when defined, mute ramps the shift by 1 per sample
//   The bus interface must be instantiated with the same DATA_W and NUM_CH.
module audio_monitor_pipeline
  import audio_pkg::*;
#(
  parameter int DATA_W       = AUDIO_DATA_W,
  parameter int NUM_CH       = 2,
  parameter int ATTEN_W      = AUDIO_ATTEN_W,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int METER_LEDS   = 8,
  parameter int HOLD_SAMPLES = 4800,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  audio_monitor_pipeline_if.slave bus,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic                  i_btn_sel,
  input  logic                  i_btn_mute,
  output logic [METER_LEDS-1:0] o_led,
  output logic [SEL_W-1:0]      o_sel_ch,
  output logic [NUM_CH-1:0]     o_mute
);
  localparam int SH_W   = $clog2(DATA_W);
  localparam int MAG_W  = DATA_W - 1;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  logic up_rise, down_rise, sel_rise, mute_rise;

  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_up), .o_rise(up_rise));
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_down), .o_rise(down_rise));
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sel (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_sel), .o_rise(sel_rise));
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mute (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_mute), .o_rise(mute_rise));

  // Control state
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [NUM_CH-1:0]              mute_q, mute_d;
  logic [NUM_CH-1:0][ATTEN_W-1:0] atten_q, atten_d;

  // Stage 1: captured samples plus the shift/zero decision frozen with them
  logic                           s1_valid_q, s1_valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  s1_data_q, s1_data_d;
  logic [NUM_CH-1:0][SH_W-1:0]    s1_shift_q, s1_shift_d;
  logic [NUM_CH-1:0]              s1_zero_q, s1_zero_d;

  // Stage 2 and meter
  logic                           o_valid_q, o_valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  o_data_q, o_data_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  y_c;
  logic [NUM_CH-1:0][MAG_W-1:0]   mag_c;
  logic [MAG_W-1:0]               mag_max;
  logic [MAG_W-1:0]               peak_q, peak_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  logic [METER_LEDS-1:0]          led_q, led_d;

`ifdef AUDIO_MON_SOFT_MUTE_EN
  logic [NUM_CH-1:0][SH_W-1:0]    ramp_q, ramp_d;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sel_q      <= '0;
      mute_q     <= '0;
      atten_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shift_q <= '0;
      s1_zero_q  <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      peak_q     <= '0;
      hold_q     <= '0;
      led_q      <= '0;
`ifdef AUDIO_MON_SOFT_MUTE_EN
      ramp_q     <= '0;
`endif
    end else begin
      sel_q      <= sel_d;
      mute_q     <= mute_d;
      atten_q    <= atten_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_shift_q <= s1_shift_d;
      s1_zero_q  <= s1_zero_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      peak_q     <= peak_d;
      hold_q     <= hold_d;
      led_q      <= led_d;
`ifdef AUDIO_MON_SOFT_MUTE_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

  // Button actions all use the pre-update sel_q, so a simultaneous sel edge
  // lets the other edge land on the old channel.
  always_comb begin
    sel_d   = sel_q;
    mute_d  = mute_q;
    atten_d = atten_q;
    if (up_rise && !down_rise && (atten_q[sel_q] != '0)) begin
      atten_d[sel_q] = atten_q[sel_q] - ATTEN_W'(1);
    end
    if (down_rise && !up_rise && (atten_q[sel_q] != '1)) begin
      atten_d[sel_q] = atten_q[sel_q] + ATTEN_W'(1);
    end
    if (mute_rise) begin
      mute_d[sel_q] = ~mute_q[sel_q];
    end
    if (sel_rise) begin
      sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  // Stage 1: the attenuation/mute state is sampled only here, so control
  // changes take effect on sample boundaries.
  always_comb begin
    s1_valid_d = bus.i_data_valid;
    s1_data_d  = s1_data_q;
    s1_shift_d = s1_shift_q;
    s1_zero_d  = s1_zero_q;
`ifdef AUDIO_MON_SOFT_MUTE_EN
    ramp_d     = ramp_q;
`endif
    if (bus.i_data_valid) begin
      s1_data_d = bus.i_data;
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef AUDIO_MON_SOFT_MUTE_EN
        // Muted: climb toward full shift. Unmuted: fall back one step at a
        // time while above atten, otherwise follow atten directly.
        if (mute_q[c]) begin
          if (ramp_q[c] < SH_W'(DATA_W - 1)) begin
            ramp_d[c] = ramp_q[c] + SH_W'(1);
          end
        end else if (ramp_q[c] > SH_W'(atten_q[c])) begin
          ramp_d[c] = ramp_q[c] - SH_W'(1);
        end else begin
          ramp_d[c] = SH_W'(atten_q[c]);
        end
        s1_shift_d[c] = ramp_d[c];
        s1_zero_d[c]  = mute_q[c] && (ramp_d[c] == SH_W'(DATA_W - 1));
`else
        s1_shift_d[c] = SH_W'(atten_q[c]);
        s1_zero_d[c]  = mute_q[c];
`endif
      end
    end
  end

  // Stage 2 datapath
  always_comb begin
    y_c   = '0;
    mag_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      y_c[c]   = s1_zero_q[c] ? '0 : DATA_W'($signed(s1_data_q[c]) >>> s1_shift_q[c]);
      mag_c[c] = MAG_W'(abs_sat(64'($signed(y_c[c])), DATA_W));
    end
  end

  // Output register and meter; the meter only moves on output samples.
  always_comb begin
    o_valid_d = s1_valid_q;
    o_data_d  = o_data_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    mag_max   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mag_c[c] > mag_max) begin
        mag_max = mag_c[c];
      end
    end
    if (s1_valid_q) begin
      o_data_d = y_c;
      if (mag_max >= peak_q) begin
        peak_d = mag_max;
        hold_d = '0;
      end else if (hold_q == HOLD_W'(HOLD_SAMPLES - 1)) begin
        peak_d = peak_q >> 1;
        hold_d = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
    for (int i = 0; i < METER_LEDS; i++) begin
      led_d[i] = (peak_d >= MAG_W'(led_threshold(DATA_W, METER_LEDS, i)));
    end
  end

  assign bus.o_data       = o_data_q;
  assign bus.o_data_valid = o_valid_q;
  assign o_led            = led_q;
  assign o_sel_ch         = sel_q;
  assign o_mute           = mute_q;
endmodule

// File: tb/tb_audio_monitor_pipeline.sv
// tb/tb_audio_monitor_pipeline.sv - scoreboard bench for audio_monitor_pipeline
module tb_audio_monitor_pipeline;
  localparam int DEB  = 8;
  localparam int HOLD = 4;
  localparam int B_UP = 0, B_DN = 1, B_SEL = 2, B_MUTE = 3, B_UPDN = 4;

  typedef struct {
    logic [47:0] data;
    logic        led_chk;
    logic [7:0]  led;
    int          issue;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_sel, btn_mute;
  logic [7:0] o_led;
  logic       o_sel_ch;
  logic [1:0] o_mute;
  int         cyc = 0;
  int         vectors = 0;
  int         fails = 0;
  exp_t       exp_q[$];

  audio_monitor_pipeline_if #(.DATA_W(24), .NUM_CH(2)) bus ();

  audio_monitor_pipeline #(
    .DATA_W(24), .NUM_CH(2), .ATTEN_W(4), .DEBOUNCE_CYC(DEB),
    .METER_LEDS(8), .HOLD_SAMPLES(HOLD)
  ) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus),
    .i_btn_up(btn_up), .i_btn_down(btn_down), .i_btn_sel(btn_sel), .i_btn_mute(btn_mute),
    .o_led(o_led), .o_sel_ch(o_sel_ch), .o_mute(o_mute)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output strobe must match the oldest expected sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_valid: got o_data=%0h with nothing expected", bus.o_data);
        end else begin
          e = exp_q.pop_front();
          check("o_data", bus.o_data, e.data);
          check("latency", cyc - e.issue, 2);
          if (e.led_chk) check("o_led", o_led, e.led);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_data_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input logic [23:0] el,
                      input logic [23:0] er, input logic [7:0] led);
    exp_t e;
    @(negedge clk);
    bus.i_data       = {r, l};
    bus.i_data_valid = 1'b1;
    e.data    = {er, el};
    e.led_chk = 1'b1;
    e.led     = led;
    e.issue   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:   btn_up = v;
      B_DN:   btn_down = v;
      B_SEL:  btn_sel = v;
      B_MUTE: btn_mute = v;
      default: begin btn_up = v; btn_down = v; end
    endcase
  endtask

  task automatic press(input int b, input int n);
    repeat (n) begin
      set_btn(b, 1'b1);
      idle(DEB + 6);
      set_btn(b, 1'b0);
      idle(DEB + 6);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_sel = 0; btn_mute = 0;
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    idle(3);
    check("rst_o_data", bus.o_data, 0);
    check("rst_o_valid", bus.o_data_valid, 0);
    check("rst_o_led", o_led, 0);
    check("rst_o_sel", o_sel_ch, 0);
    check("rst_o_mute", o_mute, 0);
    rst = 1'b0;
    idle(2);

    // 1: unity passthrough, 2-cycle latency
    send(24'h100000, 24'hF00000, 24'h100000, 24'hF00000, 8'h3F);
    idle(4);

    // 2: three steps of attenuation on ch0, then saturation at 15
    press(B_DN, 3);
    send(24'h400000, 24'hF00000, 24'h080000, 24'hF00000, 8'h3F);
    idle(4);
    press(B_DN, 20);
    send(24'h400000, 24'hF00000, 24'h000080, 24'hF00000, 8'h3F);
    send(24'hC00000, 24'hF00000, 24'hFFFF80, 24'hF00000, 8'h3F);
    idle(4);

    // 3: bounce gives exactly one step; up+down together gives none
    do_reset();
    press(B_DN, 2);
    for (int k = 0; k < 10; k++) begin
      btn_up = ~btn_up;
      idle(3);
    end
    press(B_UP, 1);
    send(24'h400000, 24'h123456, 24'h200000, 24'h123456, 8'h7F);
    idle(4);
    press(B_UPDN, 1);
    send(24'h400000, 24'h123456, 24'h200000, 24'h123456, 8'h7F);
    idle(4);

    // 4: peak hold and decay, no decay without samples, most-negative input
    do_reset();
    send(24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 8'hFF);
    for (int k = 1; k <= 2 * HOLD; k++) begin
      send(24'h0, 24'h0, 24'h0, 24'h0, (k < HOLD) ? 8'hFF : (k < 2 * HOLD) ? 8'h7F : 8'h3F);
    end
    idle(20);
    check("no_decay_idle", o_led, 8'h3F);
    send(24'h800000, 24'h000000, 24'h800000, 24'h000000, 8'hFF);
    idle(4);

    // 5: select ch1, mute it, back-to-back samples
    do_reset();
    press(B_SEL, 1);
    check("sel_ch1", o_sel_ch, 1);
    press(B_MUTE, 1);
    check("mute_ch1", o_mute, 2'b10);
`ifdef AUDIO_MON_SOFT_MUTE_EN
    send(24'h111111, 24'h222222, 24'h111111, 24'h111111, 8'h3F);
    send(24'h111111, 24'h222222, 24'h111111, 24'h088888, 8'h3F);
    send(24'h111111, 24'h222222, 24'h111111, 24'h044444, 8'h3F);
`else
    send(24'h111111, 24'h222222, 24'h111111, 24'h000000, 8'h3F);
    send(24'h111111, 24'h222222, 24'h111111, 24'h000000, 8'h3F);
    send(24'h111111, 24'h222222, 24'h111111, 24'h000000, 8'h3F);
`endif
    idle(4);
    press(B_SEL, 1);
    check("sel_wrap", o_sel_ch, 0);
    press(B_MUTE, 1);
    check("mute_both", o_mute, 2'b11);
`ifdef AUDIO_MON_SOFT_MUTE_EN
    send(24'h111111, 24'h222222, 24'h088888, 24'h022222, 8'h3F);
`else
    send(24'h111111, 24'h222222, 24'h000000, 24'h000000, 8'h3F);
`endif
    idle(4);

    // 6: reset with a sample in flight drops it
    @(negedge clk);
    bus.i_data       = {24'h333333, 24'h444444};
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    rst = 1'b1;
    idle(3);
    check("midrst_o_valid", bus.o_data_valid, 0);
    check("midrst_o_data", bus.o_data, 0);
    check("midrst_o_led", o_led, 0);
    check("midrst_o_mute", o_mute, 0);
    check("midrst_o_sel", o_sel_ch, 0);
    rst = 1'b0;
    idle(4);
    check("post_rst_o_data", bus.o_data, 0);
    send(24'h010000, 24'hFF0000, 24'h010000, 24'hFF0000, 8'h03);
    idle(6);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
